// File: rtl/calc_datapath_if.sv
// Keypad-side control/digit inputs and display-side outputs of the calculator datapath.
interface calc_datapath_if #(
  parameter int W = 16
);
  logic         esc;
  logic [2:0]   current_state;
  logic [1:0]   calcul;
  logic         digit_valid;
  logic [3:0]   digit;
  logic [W-1:0] disp_val;
  logic         disp_neg;
  logic         result_valid;
  logic         busy;
  logic         err;

  modport master (
    output esc, current_state, calcul, digit_valid, digit,
    input  disp_val, disp_neg, result_valid, busy, err
  );

  modport slave (
    input  esc, current_state, calcul, digit_valid, digit,
    output disp_val, disp_neg, result_valid, busy, err
  );
endinterface

// File: rtl/calc_datapath.sv
// Calculator operand builder and ALU: decimal digit entry, add/sub/mul in one cycle,
// restoring divide at one quotient bit per cycle, registered display select.
module calc_datapath #(
  parameter int W    = 16,
  parameter int MAXD = 4
) (
  input  logic           clk,
  input  logic           rst,
  calc_datapath_if.slave bus
);
  localparam int CW = $clog2(MAXD + 1);
  localparam int IW = $clog2(W);
  localparam logic [2:0] S_FIRST  = 3'd0;
  localparam logic [2:0] S_CALC   = 3'd1;
  localparam logic [2:0] S_SECOND = 3'd2;
  localparam logic [2:0] S_ENTER  = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;
  localparam logic [2:0] S_CONT   = 3'd5;
  localparam logic [IW-1:0] LAST  = IW'(W - 1);

  logic [W-1:0]   opa, opb, result, disp, quo, rem, dvs;
  logic           neg, rv, busy, err, pend, disp_neg;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  iter;

  logic [2:0]     st;
  logic           dig_ok, ge;
  logic [W-1:0]   dig_w, opa_next, opb_next, quo_next;
  logic [W:0]     sum, trial, sub_t;
  logic [2*W-1:0] prod;

  assign st       = bus.current_state;
  assign dig_ok   = bus.digit_valid && (bus.digit <= 4'd9) && (int'(cnt) < MAXD) && !busy;
  assign dig_w    = W'(bus.digit);
  assign opa_next = opa * W'(10) + dig_w;
  assign opb_next = opb * W'(10) + dig_w;
  assign sum      = {1'b0, opa} + {1'b0, opb};
  assign prod     = (2*W)'(opa) * (2*W)'(opb);

  // Restoring step: shift the next dividend bit into the partial remainder and
  // subtract when it does not borrow (remainder < divisor keeps the difference in W bits).
  assign trial    = {rem, quo[W-1]};
  assign sub_t    = trial - {1'b0, dvs};
  assign ge       = ~sub_t[W];
  assign quo_next = {quo[W-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst || bus.esc) begin
      opa      <= '0;
      opb      <= '0;
      result   <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      rv       <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      pend     <= 1'b0;
      disp     <= '0;
      disp_neg <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      iter     <= '0;
    end else if (st <= S_CONT) begin
      if (busy) begin
        quo  <= quo_next;
        rem  <= ge ? sub_t[W-1:0] : trial[W-1:0];
        iter <= iter + 1'b1;
        if (iter == LAST) begin
          busy   <= 1'b0;
          result <= quo_next;
          // A continue seen during the divide chains the quotient straight into A.
          if (pend || st == S_CONT) begin
            opa  <= quo_next;
            opb  <= '0;
            cnt  <= '0;
            rv   <= 1'b0;
            err  <= 1'b0;
            neg  <= 1'b0;
            pend <= 1'b0;
          end else begin
            rv <= 1'b1;
          end
        end else if (st == S_CONT) begin
          pend <= 1'b1;
        end
      end

      case (st)
        S_FIRST: if (dig_ok) begin
          opa <= opa_next;
          cnt <= cnt + 1'b1;
        end
        S_CALC: begin
          opb <= '0;
          cnt <= '0;
          rv  <= 1'b0;
          err <= 1'b0;
        end
        S_SECOND: if (dig_ok) begin
          opb <= opb_next;
          cnt <= cnt + 1'b1;
        end
        S_ENTER: if (!busy) begin
          neg  <= 1'b0;
          err  <= 1'b0;
          rv   <= 1'b1;
          pend <= 1'b0;
          case (bus.calcul)
            2'b00: begin
              if (sum[W]) begin
                err    <= 1'b1;
                result <= '0;
              end else begin
                result <= sum[W-1:0];
              end
            end
            2'b01: begin
              if (opa >= opb) begin
                result <= opa - opb;
              end else begin
                result <= opb - opa;
                neg    <= 1'b1;
              end
            end
            2'b10: begin
              if (|prod[2*W-1:W]) begin
                err    <= 1'b1;
                result <= '0;
              end else begin
                result <= prod[W-1:0];
              end
            end
            default: begin
              if (opb == '0) begin
                err    <= 1'b1;
                result <= '0;
              end else begin
                rv   <= 1'b0;
                busy <= 1'b1;
                iter <= '0;
                rem  <= '0;
                quo  <= opa;
                dvs  <= opb;
              end
            end
          endcase
        end
        S_CONT: if (!busy) begin
          opa <= err ? '0 : result;
          opb <= '0;
          cnt <= '0;
          rv  <= 1'b0;
          err <= 1'b0;
          neg <= 1'b0;
        end
        default: ;
      endcase

      // Display samples the registers as they were before this edge.
      case (st)
        S_FIRST, S_CALC, S_CONT: begin
          disp     <= opa;
          disp_neg <= 1'b0;
        end
        S_SECOND: begin
          disp     <= (cnt != '0) ? opb : opa;
          disp_neg <= 1'b0;
        end
        default: begin
          disp     <= rv ? result : '0;
          disp_neg <= rv & neg;
        end
      endcase
    end
  end

  assign bus.disp_val     = disp;
  assign bus.disp_neg     = disp_neg;
  assign bus.result_valid = rv;
  assign bus.busy         = busy;
  assign bus.err          = err;
endmodule
